// File: rtl/deadlock_mon_pkg.sv
// Shared types and default parameters for the deadlock event logger slice.
package deadlock_mon_pkg;

  localparam int unsigned DL_N_INST = 5;
  localparam int unsigned DL_N_AXIS = 2;
  localparam int unsigned DL_THRESH = 16;
  localparam int unsigned DL_TS_W   = 32;
  localparam int unsigned DL_CNT_W  = 8;
  localparam int unsigned DL_IDX_W  = $clog2(DL_N_INST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } dl_state_e;

  // Report payload layout at the default parameter set.
  typedef struct packed {
    logic [DL_TS_W-1:0]   ts;
    logic [DL_N_INST-1:0] inst;
    logic [DL_N_AXIS-1:0] axis;
    logic [DL_IDX_W-1:0]  first_idx;
    logic                 first_vld;
  } dl_report_t;

endpackage

// File: rtl/deadlock_prio_enc.sv
// Lowest-set-bit encoder: idx of the lowest asserted bit, vld if any bit is set.
module deadlock_prio_enc #(
  parameter  int unsigned N     = 5,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     sigs,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!vld && sigs[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/deadlock_event_logger.sv
// Debounces kernel_block, captures one snapshot per continuous deadlock and
// presents it on a valid/ready report port with a sticky flag and event count.
module deadlock_event_logger
  import deadlock_mon_pkg::*;
#(
  parameter  int unsigned N_INST = DL_N_INST,
  parameter  int unsigned N_AXIS = DL_N_AXIS,
  parameter  int unsigned THRESH = DL_THRESH,
  parameter  int unsigned TS_W   = DL_TS_W,
  parameter  int unsigned CNT_W  = DL_CNT_W,
  localparam int unsigned IDX_W  = $clog2(N_INST)
) (
  input  logic              kernel_monitor_clock,
  input  logic              kernel_monitor_reset,
  input  logic              kernel_block,
  input  logic [N_INST-1:0] inst_block_sigs,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic              clear,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [TS_W-1:0]   rpt_ts,
  output logic [N_INST-1:0] rpt_inst_block,
  output logic [N_AXIS-1:0] rpt_axis_block,
  output logic [IDX_W-1:0]  rpt_first_idx,
  output logic              rpt_first_vld,
  output logic              deadlock,
  output logic [CNT_W-1:0]  event_count
);

  localparam int unsigned Q_W = $clog2(THRESH);

  dl_state_e        state, state_d;
  logic [TS_W-1:0]  ts;
  logic [Q_W-1:0]   qcnt;
  logic [TS_W-1:0]  pend_ts;
  logic [IDX_W-1:0] pend_idx;
  logic             pend_vld;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_vld;
  logic             start_q, adv_q, qualify, handshake;

  deadlock_prio_enc #(.N(N_INST)) u_prio_enc (
    .sigs (inst_block_sigs),
    .idx  (enc_idx),
    .vld  (enc_vld)
  );

  // State register.
  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) state <= IDLE;
    else                      state <= state_d;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d   = state;
    start_q   = 1'b0;
    adv_q     = 1'b0;
    qualify   = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (kernel_block) begin
          state_d = QUAL;
          start_q = 1'b1;
        end
      end
      QUAL: begin
        if (!kernel_block) begin
          state_d = IDLE;
        end else if (qcnt == Q_W'(THRESH - 1)) begin
          state_d = REPORT;
          qualify = 1'b1;
        end else begin
          adv_q = 1'b1;
        end
      end
      REPORT: begin
        if (rpt_valid && rpt_ready) begin
          state_d   = HOLD;
          handshake = 1'b1;
        end
      end
      HOLD: begin
        if (!kernel_block) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Timestamp, qualification bookkeeping and report registers.
  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) begin
      ts             <= '0;
      qcnt           <= '0;
      pend_ts        <= '0;
      pend_idx       <= '0;
      pend_vld       <= 1'b0;
      rpt_valid      <= 1'b0;
      rpt_ts         <= '0;
      rpt_inst_block <= '0;
      rpt_axis_block <= '0;
      rpt_first_idx  <= '0;
      rpt_first_vld  <= 1'b0;
      deadlock       <= 1'b0;
      event_count    <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      if (start_q) begin
        pend_ts  <= ts;
        pend_idx <= enc_idx;
        pend_vld <= enc_vld;
        qcnt     <= Q_W'(1);
      end
      if (adv_q) qcnt <= qcnt + Q_W'(1);
      if (qualify) begin
        rpt_valid      <= 1'b1;
        rpt_ts         <= pend_ts;
        rpt_first_idx  <= pend_idx;
        rpt_first_vld  <= pend_vld;
        rpt_inst_block <= inst_block_sigs;
        rpt_axis_block <= axis_block_sigs;
        deadlock       <= 1'b1;
        if (event_count != '1) event_count <= event_count + CNT_W'(1);
      end
      if (handshake) rpt_valid <= 1'b0;
      // Clear overrides a coinciding qualification; the report still goes out.
      if (clear) begin
        deadlock    <= 1'b0;
        event_count <= '0;
      end
    end
  end

endmodule

// File: doc/deadlock_event_logger.md
# deadlock_event_logger

Downstream consumer of the kernel deadlock monitor's `kernel_block` output in the co-simulation deadlock-detection tree. It debounces `kernel_block`: the signal must stay high for `THRESH` consecutive cycles before it counts. On a qualified deadlock it captures one stable snapshot:

- the per-instance block vector and per-AXIS block vector;
- the lowest-index blocked process;
- a cycle timestamp.

It presents that snapshot through a valid/ready report port. It keeps a sticky `deadlock` flag and a saturating event count, and re-arms only after `kernel_block` deasserts.

## Interface
Parameters:
- `N_INST`, 5: number of dataflow process block bits.
- `N_AXIS`, 2: number of AXIS block bits.
- `THRESH`, 16: consecutive high samples needed to qualify (legal ≥ 2).
- `TS_W`, 32: timestamp width.
- `CNT_W`, 8: event counter width.

Ports:
- `kernel_monitor_clock`  in  1  sole clock. Everything is on its rising edge.
- `kernel_monitor_reset`  in  1  synchronous, active-high reset.
- `kernel_block`  in  1  aggregate block from the deadlock monitor.
- `inst_block_sigs`  in  N_INST  per-process block bits.
- `axis_block_sigs`  in  N_AXIS  per-AXIS-port block bits.
- `clear`  in  1  clears `deadlock` and `event_count`.
- `rpt_valid`  out  1  report available.
- `rpt_ready`  in  1  report consumer ready.
- `rpt_ts`  out  TS_W  cycle count when qualification started.
- `rpt_inst_block`  out  N_INST  snapshot of `inst_block_sigs`.
- `rpt_axis_block`  out  N_AXIS  snapshot of `axis_block_sigs`.
- `rpt_first_idx`  out  $clog2(N_INST)  lowest set index of `inst_block_sigs`.
- `rpt_first_vld`  out  1  1 if any `inst_block_sigs` bit was set.
- `deadlock`  out  1  sticky; set by a qualified event.
- `event_count`  out  CNT_W  number of qualified events, saturating.

## Operation
- A free-running `ts` counter of width `TS_W` increments every cycle and wraps from all-ones to 0.
- States:
  - **IDLE**. On a `kernel_block`=1 sample: capture `ts` into the pending timestamp, capture the priority-encoded `inst_block_sigs` (first_idx/first_vld), set `qcnt`=1, go to QUAL.
  - **QUAL**.
    - `kernel_block`=0: go to IDLE and discard the pending data. No event, no flag.
    - Else if `qcnt`==THRESH-1: go to REPORT. Snapshot `inst_block_sigs` and `axis_block_sigs` on this cycle, set `deadlock`, increment `event_count` (it saturates at all-ones).
    - Else `qcnt`++.
  - **REPORT**. `rpt_valid`=1. All `rpt_*` fields stay stable until `rpt_valid`&&`rpt_ready`. On that handshake go to HOLD. `kernel_block` is ignored in this state.
  - **HOLD**. Wait for a `kernel_block`=0 sample, then go to IDLE. This prevents repeat reports for one continuous block.
- `first_idx` and `first_vld` are taken on the QUAL entry cycle, not on the snapshot cycle. The block vectors are taken on the snapshot cycle.
- `clear` is accepted in any state. It zeroes `deadlock` and `event_count` and does not change FSM state.
  - If `clear` coincides with a qualifying cycle, clear wins: `deadlock`=0 and `event_count`=0. The report is still issued.
- Reset values: state IDLE, `ts`=0, `qcnt`=0, `rpt_valid`=0, all `rpt_*`=0, `deadlock`=0, `event_count`=0.
  - Reset in REPORT drops the pending report without a handshake.

## Timing
- `kernel_block` sampled high at edges t .. t+THRESH-1 → `rpt_valid`, `deadlock` and the new `event_count` are visible after edge t+THRESH-1.
- `rpt_ts` = `ts` value present at edge t.
- A low sample at any edge t+k with k<THRESH aborts qualification. A new qualification can start on the next high sample.
- `rpt_ready` may be high before `rpt_valid`. The handshake completes on the first edge where both are high, and `rpt_valid` is low after that edge.
- Minimum spacing between two reports is THRESH+2 cycles. It requires the handshake and one low sample in HOLD.
- Outputs are registered only. There is no combinational path from any input to any output.

## Structure
- Package `deadlock_mon_pkg`:
  - state enum `dl_state_e` {IDLE, QUAL, REPORT, HOLD};
  - default parameter constants;
  - a report struct type with fields ts, inst, axis, first_idx, first_vld.
- Sub-module `deadlock_prio_enc`: parameterised lowest-set-bit encoder producing idx and vld. It is combinational and is instantiated once.

## Test plan
- THRESH=16. `kernel_block` high 15 cycles, then low → `rpt_valid` never asserts, `deadlock`=0, `event_count`=0.
- `kernel_block` high from `ts`=100 for 40 cycles, `inst_block_sigs`=5'b10100, `axis_block_sigs`=2'b01, `rpt_ready`=1:
  - `rpt_valid` for exactly 1 cycle after the 16th sample;
  - `rpt_ts`=100, `rpt_first_idx`=2, `rpt_first_vld`=1, `rpt_inst_block`=5'b10100, `rpt_axis_block`=2'b01;
  - `event_count`=1 and no second report while high.
- `rpt_ready` held 0 for 20 cycles during REPORT while the inputs change → all `rpt_*` fields stay constant. Raising `rpt_ready` completes the handshake in 1 cycle.
- 300 qualified events with CNT_W=8 → `event_count` saturates at 255. `clear` pulse → `event_count`=0, `deadlock`=0.
- `clear` asserted on the qualifying cycle → report issued, `deadlock`=0, `event_count`=0. Separately, reset asserted mid-REPORT → `rpt_valid`=0 next cycle and all outputs return to their reset values.
- `ts` preloaded to all-ones via reset release timing with TS_W=4 → `ts` wraps to 0 and a report started at `ts`=15 carries `rpt_ts`=15.
